// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default image geometry, window pipeline depth, row counter width.
package edge_pkg;

    // Default frame geometry.
    localparam int IMG_WIDTH_DEF  = 100;
    localparam int IMG_HEIGHT_DEF = 100;

    // Accept-to-window latency: one cycle to write the buffer, one for the taps to settle.
    localparam int WIN_LATENCY = 2;

    // Row counter width, enough for 1024 rows.
    localparam int ROW_W = 10;

    // Line-buffer controller FSM states.
    typedef logic [1:0] lb_state_t;
    localparam lb_state_t ST_IDLE = 2'd0;
    localparam lb_state_t ST_FILL = 2'd1;
    localparam lb_state_t ST_RUN  = 2'd2;
    localparam lb_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/raster_counter.sv
// Raster column/row position counter with wrap, clear and enable.
// Latency: position updates on the edge after en/clr; flags are combinational from the position.
// Backpressure: none; advances only when en is high.
// Ports: clr forces the current beat to be treated as pixel (0,0); en consumes one pixel;
//        col/row hold the position of the next expected pixel; last_col/last_pix flag the row/frame end.
module raster_counter #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_col,
    output logic             last_pix
);

    logic [COL_W-1:0] base_col;
    logic [ROW_W-1:0] base_row;
    logic             base_last;

    // When clr and en coincide the beat itself is pixel (0,0), so advance from origin.
    always_comb begin
        base_col  = clr ? '0 : col;
        base_row  = clr ? '0 : row;
        base_last = (base_col == COL_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (base_last) begin
                col <= '0;
                row <= base_row + ROW_W'(1);
            end else begin
                col <= base_col + COL_W'(1);
                row <= base_row;
            end
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end
    end

    assign last_col = (col == COL_W'(WIDTH - 1));
    assign last_pix = last_col && (row == ROW_W'(HEIGHT - 1));

endmodule

// File: rtl/shift_8_multi_read.sv
// Two-row line buffer with a 3x3 tap window shifted on every column write.
// Latency: taps reflect a write one edge after write_en.
// Backpressure: none; accepts a write every cycle.
// Ports: write_en/addr/wr_data write the current pixel at its column;
//        taps[r][c] is row r (0 = oldest row) and column c (2 = newest column).
module shift_8_multi_read #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         write_en,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [2:0][2:0][DATA_W-1:0]  taps
);

    localparam int DEPTH = 2 ** ADDR_W;

    // line0 holds the previous row, line1 the row before that.
    logic [DATA_W-1:0] line0 [DEPTH];
    logic [DATA_W-1:0] line1 [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            line0[addr] <= wr_data;
            line1[addr] <= line0[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (write_en) begin
            for (int r = 0; r < 3; r++) begin
                taps[r][0] <= taps[r][1];
                taps[r][1] <= taps[r][2];
            end
            taps[0][2] <= line1[addr];
            taps[1][2] <= line0[addr];
            taps[2][2] <= wr_data;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: raster pixel stream in, buffer writes and 3x3 window strobes out.
// Latency: accept at N -> mem_write_en at N+1, win_valid at N+2; one pixel per cycle.
// Backpressure: in_ready drops only for the single DONE cycle after a frame; no window backpressure.
// Ports: in_valid/in_ready/in_data/in_sof pixel input; mem_* buffer write; win_* window centre strobe;
//        frame_done pulses after the last pixel; sof_err pulses when a frame is restarted mid-way.
module line_buffer_ctrl
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic [ROW_W-1:0]  win_row,
    output logic              frame_done,
    output logic              sof_err
);

    lb_state_t state, state_nxt;

    logic              accept;
    logic              in_frame;
    logic              sof_hit;
    logic              wr_beat;
    logic              win_hit;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic              last_col;
    logic              last_pix;

    // Taps feed the Sobel stage, which sits outside this controller.
    logic [2:0][2:0][DATA_W-1:0] win_taps_unused;

    // Window pipeline: stage 0 is loaded at the accept edge, the last stage drives the outputs.
    logic [WIN_LATENCY-1:0] win_v_pipe;
    logic [ADDR_W-1:0]      win_c_pipe [WIN_LATENCY];
    logic [ROW_W-1:0]       win_r_pipe [WIN_LATENCY];

    // Held low during reset so upstream never sees a spurious ready.
    assign in_ready   = rst_n && (state != ST_DONE);
    assign frame_done = (state == ST_DONE);

    assign accept   = in_valid && in_ready;
    assign in_frame = (state == ST_FILL) || (state == ST_RUN);
    assign sof_hit  = accept && in_sof;
    // IDLE beats without SOF are swallowed without a write.
    assign wr_beat  = accept && (in_sof || in_frame);
    // A window needs two rows above and two columns to the left; the centre lags by one in both.
    assign win_hit  = accept && !in_sof && (state == ST_RUN) && (col >= ADDR_W'(2));

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .COL_W  (ADDR_W),
        .ROW_W  (ROW_W)
    ) u_raster (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sof_hit),
        .en       (wr_beat),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sof_hit) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (sof_hit) begin
                    state_nxt = ST_FILL;
                end else if (accept && last_col && (row == ROW_W'(1))) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sof_hit) begin
                    state_nxt = ST_FILL;
                end else if (accept && last_pix) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer write stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            sof_err      <= 1'b0;
        end else begin
            mem_write_en <= wr_beat;
            sof_err      <= sof_hit && in_frame;
            if (wr_beat) begin
                mem_addr    <= in_sof ? '0 : col;
                mem_wr_data <= in_data;
            end
        end
    end

    // Window strobe pipeline; coordinates only load on a real window so idle cycles leave them quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_v_pipe <= '0;
            for (int k = 0; k < WIN_LATENCY; k++) begin
                win_c_pipe[k] <= '0;
                win_r_pipe[k] <= '0;
            end
        end else begin
            win_v_pipe <= {win_v_pipe[WIN_LATENCY-2:0], win_hit};
            if (win_hit) begin
                win_c_pipe[0] <= col - ADDR_W'(1);
                win_r_pipe[0] <= row - ROW_W'(1);
            end
            for (int k = 1; k < WIN_LATENCY; k++) begin
                win_c_pipe[k] <= win_c_pipe[k-1];
                win_r_pipe[k] <= win_r_pipe[k-1];
            end
        end
    end

    assign win_valid = win_v_pipe[WIN_LATENCY-1];
    assign win_col   = win_c_pipe[WIN_LATENCY-1];
    assign win_row   = win_r_pipe[WIN_LATENCY-1];

    shift_8_multi_read #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_linebuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .write_en (mem_write_en),
        .addr     (mem_addr),
        .wr_data  (mem_wr_data),
        .taps     (win_taps_unused)
    );

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl with a 4x4 frame.
// Latency: n/a.
// Backpressure: n/a.
module tb_line_buffer_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NC = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          win_valid;
    logic [AW-1:0] win_col;
    logic [9:0]    win_row;
    logic          frame_done;
    logic          sof_err;

    line_buffer_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .win_valid    (win_valid),
        .win_col      (win_col),
        .win_row      (win_row),
        .frame_done   (frame_done),
        .sof_err      (sof_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle, filled by the reference model.
    bit            exp_we   [NC];
    logic [AW-1:0] exp_addr [NC];
    logic [DW-1:0] exp_data [NC];
    bit            exp_wv   [NC];
    logic [AW-1:0] exp_wc   [NC];
    logic [9:0]    exp_wr   [NC];
    bit            exp_fd   [NC];
    bit            exp_se   [NC];
    bit            exp_nrdy [NC];

    // Reference model: frame membership and pixel index within the frame.
    bit m_in_frame = 1'b0;
    int m_p = 0;

    int n_vec = 0;
    int n_err = 0;
    int obs_we = 0, obs_wv = 0, obs_fd = 0, obs_nrdy = 0;

    bit            cur_v;
    bit            cur_sof;
    logic [DW-1:0] cur_d;

    typedef struct {
        bit            v;
        bit            sof;
        logic [DW-1:0] d;
        bit            rdy;
        bit            we;
        logic [AW-1:0] addr;
        bit            wv;
        logic [AW-1:0] wc;
        logic [9:0]    wr;
        bit            fd;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(bit v, bit s, int d, bit rdy, bit we, int addr,
                                bit wv, int wc, int wr, bit fd);
        vec_t r;
        r.v = v; r.sof = s; r.d = DW'(d); r.rdy = rdy; r.we = we; r.addr = AW'(addr);
        r.wv = wv; r.wc = AW'(wc); r.wr = 10'(wr); r.fd = fd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < NC; i++) begin
            exp_we[i] = 0; exp_addr[i] = '0; exp_data[i] = '0;
            exp_wv[i] = 0; exp_wc[i] = '0; exp_wr[i] = '0;
            exp_fd[i] = 0; exp_se[i] = 0; exp_nrdy[i] = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_write_en"}, mem_write_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wr_data"}, mem_wr_data, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_col"}, win_col, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_sof_err"}, sof_err, 0);
    endtask

    // Drive one cycle's inputs (just after the edge) and check outputs at mid-cycle.
    task automatic apply(input bit v, input bit s, input logic [DW-1:0] d);
        int c;
        in_valid = v; in_sof = s; in_data = d;
        cur_v = v; cur_sof = s; cur_d = d;
        #4;
        c = cyc;
        chk("in_ready", in_ready, !exp_nrdy[c]);
        chk("write_en", mem_write_en, exp_we[c]);
        if (exp_we[c]) begin
            chk("addr", mem_addr, exp_addr[c]);
            chk("wr_data", mem_wr_data, exp_data[c]);
        end
        chk("win_valid", win_valid, exp_wv[c]);
        if (exp_wv[c]) begin
            chk("win_col", win_col, exp_wc[c]);
            chk("win_row", win_row, exp_wr[c]);
        end
        chk("frame_done", frame_done, exp_fd[c]);
        chk("sof_err", sof_err, exp_se[c]);
        if (mem_write_en) obs_we++;
        if (win_valid)    obs_wv++;
        if (frame_done)   obs_fd++;
        if (!in_ready)    obs_nrdy++;
    endtask

    // Feed the accepted beat (as the model sees it) to the reference model, then move to the next cycle.
    task automatic commit();
        int c;
        bit acc;
        int col, row;
        c   = cyc;
        acc = cur_v && !exp_nrdy[c];
        if (acc && cur_sof) begin
            if (m_in_frame) exp_se[c+1] = 1;
            m_p = 0;
            m_in_frame = 1;
        end
        if (acc && m_in_frame) begin
            col = m_p % W;
            row = m_p / W;
            exp_we[c+1]   = 1;
            exp_addr[c+1] = AW'(col);
            exp_data[c+1] = cur_d;
            if (row >= 2 && col >= 2) begin
                exp_wv[c+2] = 1;
                exp_wc[c+2] = AW'(col - 1);
                exp_wr[c+2] = 10'(row - 1);
            end
            m_p++;
            if (m_p == W * H) begin
                exp_fd[c+1]   = 1;
                exp_nrdy[c+1] = 1;
                m_in_frame    = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
        apply(v, s, d);
        commit();
    endtask

    initial begin
        // Clean 4x4 frame: inputs and hand-derived outputs seen in the same cycle.
        tbl[0]  = mk(1, 1, 'h100, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 'h101, 1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 'h102, 1, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 'h103, 1, 1, 2, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 'h104, 1, 1, 3, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 'h105, 1, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 'h106, 1, 1, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 'h107, 1, 1, 2, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 'h108, 1, 1, 3, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 'h109, 1, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 'h10a, 1, 1, 1, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 'h10b, 1, 1, 2, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 'h10c, 1, 1, 3, 1, 1, 1, 0);
        tbl[13] = mk(1, 0, 'h10d, 1, 1, 0, 1, 2, 1, 0);
        tbl[14] = mk(1, 0, 'h10e, 1, 1, 1, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 'h10f, 1, 1, 2, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0,     0, 1, 3, 1, 1, 2, 1);
        tbl[17] = mk(0, 0, 0,     1, 0, 0, 1, 2, 2, 0);
        tbl[18] = mk(0, 0, 0,     1, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        clear_from(0);
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pre-SOF garbage: consumed without writes, controller stays idle.
        for (int i = 0; i < 5; i++) step(1, 0, DW'(32'hdead0000 + i));

        // Clean frame against the hand-written table.
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].v, tbl[i].sof, tbl[i].d);
            chk("tbl_in_ready", in_ready, tbl[i].rdy);
            chk("tbl_write_en", mem_write_en, tbl[i].we);
            if (tbl[i].we) chk("tbl_addr", mem_addr, tbl[i].addr);
            chk("tbl_win_valid", win_valid, tbl[i].wv);
            if (tbl[i].wv) begin
                chk("tbl_win_col", win_col, tbl[i].wc);
                chk("tbl_win_row", win_row, tbl[i].wr);
            end
            chk("tbl_frame_done", frame_done, tbl[i].fd);
            commit();
        end

        // Bubbles: a beat every other cycle.
        obs_we = 0; obs_wv = 0;
        for (int i = 0; i < 32; i++) step(i % 2 == 0, i == 0, $urandom);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("bubble_writes", obs_we, 16);
        chk("bubble_windows", obs_wv, 4);

        // Mid-frame SOF on the seventh beat (row 1, col 2), then the restarted frame completes.
        obs_fd = 0;
        step(1, 1, $urandom);
        for (int i = 0; i < 5; i++) step(1, 0, $urandom);
        step(1, 1, $urandom);
        for (int i = 0; i < 15; i++) step(1, 0, $urandom);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("midsof_frame_done", obs_fd, 1);

        // DONE stall: valid held high across the frame end, next beat carries SOF.
        obs_nrdy = 0;
        step(1, 1, $urandom);
        for (int i = 0; i < 15; i++) step(1, 0, $urandom);
        step(1, 1, $urandom);
        step(1, 1, $urandom);
        chk("done_stall_len", obs_nrdy, 1);
        for (int i = 0; i < 15; i++) step(1, 0, $urandom);
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            bit v, s;
            v = ($urandom % 4) != 0;
            s = m_in_frame ? (($urandom % 97) == 0) : (($urandom % 3) == 0);
            step(v, s, $urandom);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        // Async reset mid-RUN with windows in flight.
        step(1, 1, $urandom);
        for (int i = 0; i < 11; i++) step(1, 0, $urandom);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        clear_from(cyc);
        m_in_frame = 0;
        m_p = 0;
        obs_wv = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        chk("post_rst_stale_win", obs_wv, 0);
        // Controller is idle again: a fresh frame runs cleanly.
        step(1, 1, $urandom);
        for (int i = 0; i < 15; i++) step(1, 0, $urandom);
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencing controller for the `shift_8_multi_read` line-buffer memory in the edge-detector datapath. It accepts a raster pixel stream over a valid/ready handshake and generates `write_en`/`addr`/`wr_data` for the buffer. It tracks column and row position and flags, per pixel, when the buffer taps hold a complete 3x3 neighbourhood for the Sobel stage. It also frames each image with start-of-frame and frame-done handling.

## Interface
Parameters:
- `IMG_WIDTH`, 100: pixels per row; legal range 3..128.
- `IMG_HEIGHT`, 100: rows per frame; legal range 3..1024.
- `ADDR_W`, 7: buffer address width.
- `DATA_W`, 32: pixel word width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: upstream pixel valid.
- `in_ready` output 1: controller can accept a pixel.
- `in_data` input DATA_W: pixel word.
- `in_sof` input 1: qualifies the current beat as pixel (0,0) of a frame.
- `mem_write_en` output 1: write strobe to the line buffer.
- `mem_addr` output ADDR_W: buffer address, equal to the column of the written pixel.
- `mem_wr_data` output DATA_W: registered copy of the accepted `in_data`.
- `win_valid` output 1: buffer taps hold a full 3x3 window this cycle.
- `win_col` output ADDR_W: window centre column.
- `win_row` output 10: window centre row.
- `frame_done` output 1: one-cycle pulse after the last pixel is accepted.
- `sof_err` output 1: one-cycle pulse when `in_sof` arrives mid-frame.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- FSM states are IDLE, FILL, RUN and DONE. Reset state is IDLE.
- **IDLE:** `in_ready`=1.
  - Beats without `in_sof` are consumed and discarded, with no write.
  - A beat with `in_sof` becomes pixel (0,0), is written, and the FSM moves to FILL.
- **FILL:** rows 0–1 are written. No window output.
  - The FSM moves to RUN when the pixel at col IMG_WIDTH-1, row 1 is accepted.
- **RUN:** rows 2..IMG_HEIGHT-1.
  - An accepted pixel with col≥2 produces a window centred at (col-1, row-1).
  - Col 0 and col 1 of each row produce no window.
- **DONE:** entered when the pixel at col IMG_WIDTH-1, row IMG_HEIGHT-1 is accepted.
  - `in_ready`=0 and `frame_done`=1 for exactly one cycle, then the FSM returns to IDLE.
- **Counters:**
  - col increments per accepted beat and wraps IMG_WIDTH-1→0.
  - row increments on each col wrap.
  - Counters are unsigned with no saturation; the wrap compare is equality against IMG_WIDTH-1.
- **`in_sof` in FILL or RUN:**
  - Pulse `sof_err`.
  - Counters restart so that the beat is pixel (0,0) of a new frame, and it is written.
  - State goes to FILL.
  - Any in-flight `win_valid` from the aborted frame still completes.
- **`in_sof` in DONE:** cannot occur, because `in_ready`=0 in DONE.
- **`rst_n` low at any time:** all state clears immediately and no pending window is emitted.
- **Reset values:** `in_ready`=0 while `rst_n` is low. All other outputs are 0: `mem_write_en`, `mem_addr`, `mem_wr_data`, `win_valid`, `win_col`, `win_row`, `frame_done`, `sof_err`.

## Timing
- `in_ready` is combinational from state only; it is 1 in IDLE/FILL/RUN and 0 in DONE. It never depends on `in_valid`.
- An accept at cycle N gives:
  - `mem_write_en`=1 at N+1, with `mem_addr`=col and `mem_wr_data`=in_data.
  - `win_valid`=1 at N+2, which allows one cycle of buffer tap settle.
- Throughput is one pixel per cycle. Back-to-back accepts produce back-to-back writes and windows.
- `frame_done` is asserted in the cycle after the last accept (state DONE). It coincides with that pixel's `mem_write_en`. The final `win_valid` follows one cycle later.
- `sof_err` is asserted in cycle N+1 relative to the offending accept.
- There is no `win_valid` backpressure; downstream must consume every cycle.

## Structure
- Shared package `edge_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_FILL`, `ST_RUN`, `ST_DONE`);
  - the default IMG_WIDTH/IMG_HEIGHT;
  - `WIN_LATENCY`=2;
  - `ROW_W`=10.
- One sub-module, `raster_counter`, implements the col/row counter with wrap, clear and enable. It outputs `col`, `row`, `last_col` and `last_pix`.
- The top level holds the FSM, the output pipeline registers, and the instantiation of `shift_8_multi_read`.

## Test plan
- **Clean frame:** W=4, H=4, 16 consecutive beats with `in_sof` on the first.
  - Expect 16 `mem_write_en` with addr sequence 0,1,2,3 repeating.
  - Expect `win_valid` for (col,row)=(2,2),(3,2),(2,3),(3,3), with centres (1,1),(2,1),(1,2),(2,2), each at accept+2.
  - Expect `frame_done` one cycle after beat 16.
- **Pre-SOF garbage:** 5 beats without `in_sof` while in IDLE.
  - Expect `in_ready`=1 throughout, no `mem_write_en`, and the state stays IDLE.
- **Bubbles:** W=4, H=4 frame with `in_valid` dropped every other cycle.
  - Expect writes and windows identical to the clean-frame test, shifted in time, with each window exactly 2 cycles after its accept.
- **Mid-frame SOF:** `in_sof` on beat 7 (row 1, col 2).
  - Expect `sof_err` pulse, next write at addr 0, and state FILL.
  - Expect the full new frame to complete with a `frame_done`.
- **DONE stall:** `in_valid` held high across the end of the frame.
  - Expect `in_ready`=0 for exactly one cycle.
  - The next beat, carrying `in_sof`, is accepted as pixel (0,0).
- **Async reset:** `rst_n` pulsed low mid-cycle during RUN.
  - Expect all outputs to go to 0 without waiting for a clock edge.
  - After release: IDLE, `in_ready`=1, and no stale `win_valid`.
